// File: rtl/dmem_cache_if.sv
// Memory-side bus of the data cache: req/ack handshake, one word per transfer.
interface dmem_cache_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_adr;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] mem_rd;
    logic                  mem_ack;

    // Cache side issues requests
    modport master (
        output mem_req, mem_we, mem_adr, mem_wd,
        input  mem_rd, mem_ack
    );

    // Memory side answers them
    modport slave (
        input  mem_req, mem_we, mem_adr, mem_wd,
        output mem_rd, mem_ack
    );
endinterface

// File: rtl/dmem_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
module dmem_cache #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [ADDR_WIDTH-1:0] cpu_adr,
    input  logic [DATA_WIDTH-1:0] cpu_wd,
    output logic [DATA_WIDTH-1:0] cpu_rd,
    output logic                  cpu_stall,
    dmem_cache_if.master          mem
);
    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {IDLE, RMISS, WRITE, RESP} state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_arr  [LINES];
    logic [DATA_WIDTH-1:0] data_arr [LINES];

    logic [ADDR_WIDTH-1:0] lat_adr_q;
    logic [DATA_WIDTH-1:0] lat_wd_q;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic                  req_q;
    logic                  we_q;

    logic [INDEX_BITS-1:0] cpu_idx, lat_idx;
    logic [TAG_W-1:0]      cpu_tag, lat_tag;
    logic                  cpu_hit, lat_hit;
    logic                  latch_adr, latch_wd, fill_en, wupd_en;
    logic                  unused_adr_bits;

    // Address split for the live core request and the latched bus request
    assign cpu_idx = cpu_adr[INDEX_BITS+1:2];
    assign cpu_tag = cpu_adr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign lat_idx = lat_adr_q[INDEX_BITS+1:2];
    assign lat_tag = lat_adr_q[ADDR_WIDTH-1:INDEX_BITS+2];
    assign cpu_hit = valid_q[cpu_idx] && (tag_arr[cpu_idx] == cpu_tag);
    assign lat_hit = valid_q[lat_idx] && (tag_arr[lat_idx] == lat_tag);

    // Byte offset is irrelevant for word accesses
    assign unused_adr_bits = ^cpu_adr[1:0];

    // Bus outputs come only from registers, never from cpu_* inputs
    assign mem.mem_req = req_q;
    assign mem.mem_we  = we_q;
    assign mem.mem_adr = lat_adr_q;
    assign mem.mem_wd  = lat_wd_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state, stall/read-data outputs and datapath strobes
    always_comb begin
        state_d   = state_q;
        cpu_stall = 1'b0;
        cpu_rd    = data_arr[cpu_idx];
        latch_adr = 1'b0;
        latch_wd  = 1'b0;
        fill_en   = 1'b0;
        wupd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_write) begin
                    cpu_stall = 1'b1;
                    latch_adr = 1'b1;
                    latch_wd  = 1'b1;
                    state_d   = WRITE;
                end else if (cpu_read && !cpu_hit) begin
                    cpu_stall = 1'b1;
                    latch_adr = 1'b1;
                    state_d   = RMISS;
                end
            end
            RMISS: begin
                cpu_stall = 1'b1;
                if (mem.mem_ack) begin
                    fill_en = 1'b1;
                    state_d = RESP;
                end
            end
            WRITE: begin
                cpu_stall = 1'b1;
                if (mem.mem_ack) begin
                    wupd_en = lat_hit;
                    state_d = RESP;
                end
            end
            RESP: begin
                cpu_rd  = resp_data_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus request registers, latched request and valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            lat_adr_q   <= '0;
            lat_wd_q    <= '0;
            resp_data_q <= '0;
            valid_q     <= '0;
        end else begin
            req_q <= (state_d == RMISS) || (state_d == WRITE);
            we_q  <= (state_d == WRITE);
            if (latch_adr) lat_adr_q <= cpu_adr;
            if (latch_wd)  lat_wd_q  <= cpu_wd;
            if (fill_en) begin
                resp_data_q      <= mem.mem_rd;
                valid_q[lat_idx] <= 1'b1;
            end
        end
    end

    // Tag/data arrays: fill on read miss, write-through update on store hit
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (fill_en) begin
                tag_arr[lat_idx]  <= lat_tag;
                data_arr[lat_idx] <= mem.mem_rd;
            end else if (wupd_en) begin
                data_arr[lat_idx] <= lat_wd_q;
            end
        end
    end
endmodule

// File: doc/dmem_cache.md
Name: dmem_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the pipelined core's data-memory port (dadr/dmemrd/dmemwd/dmemread/dmemwrite) and a multi-cycle memory bus with a req/ack handshake.
- Read hits return data combinationally with no stall.
- Read misses and all writes raise cpu_stall. The core holds its request stable until stall drops.

Parameters:
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 32, byte address width
- INDEX_BITS, 4, log2 of line count (16 lines, one word per line)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- cpu_read  input  1  load request (core dmemread)
- cpu_write  input  1  store request (core dmemwrite)
- cpu_adr  input  ADDR_WIDTH  byte address (core dadr)
- cpu_wd  input  DATA_WIDTH  store data (core dmemwd)
- cpu_rd  output  DATA_WIDTH  load data (core dmemrd)
- cpu_stall  output  1  core must freeze pipeline and hold request
- mem_req  output  1  bus request
- mem_we  output  1  bus write enable
- mem_adr  output  ADDR_WIDTH  bus byte address
- mem_wd  output  DATA_WIDTH  bus write data
- mem_rd  input  DATA_WIDTH  bus read data, valid with mem_ack
- mem_ack  input  1  one-cycle completion pulse

Behaviour:
- Address split:
  - adr[1:0] is ignored.
  - index = adr[INDEX_BITS+1:2].
  - tag = adr[ADDR_WIDTH-1:INDEX_BITS+2].
- Per line storage: valid bit, tag, data word.
- hit = valid[index] & (tag_array[index] == tag).
- FSM states: IDLE, RMISS, WRITE, RESP.
- IDLE:
  - cpu_write=1: cpu_stall=1 combinationally. Latch adr and wd. Go to WRITE. Write wins if both read and write are asserted; that case is illegal but defined.
  - cpu_read=1 and hit: cpu_stall=0, cpu_rd = data_array[index]. Stay in IDLE.
  - cpu_read=1 and miss: cpu_stall=1. Latch adr. Go to RMISS.
  - Neither asserted: cpu_stall=0, cpu_rd = data_array[index] (don't-care).
- RMISS:
  - Outputs: mem_req=1, mem_we=0, mem_adr = latched adr; cpu_stall=1.
  - On mem_ack: write valid, tag and data (= mem_rd) into the line, capture mem_rd in resp_data, go to RESP.
- WRITE:
  - Outputs: mem_req=1, mem_we=1, mem_adr/mem_wd = latched values; cpu_stall=1.
  - On mem_ack:
    - If the latched address hits, update data_array with latched wd.
    - If it misses, the line is untouched (no allocate).
  - Go to RESP.
- RESP:
  - Outputs: cpu_stall=0, cpu_rd = resp_data; the core retires the access this cycle.
  - Next state: IDLE unconditionally.
  - The hit path is not re-evaluated in RESP, so a held request is never serviced twice.
- Bus handshake rules:
  - mem_req, mem_we, mem_adr and mem_wd are driven only from state and latched registers; no combinational path from cpu_* inputs.
  - mem_adr, mem_wd and mem_we are stable while mem_req=1.
  - mem_req deasserts in the cycle after mem_ack.
  - mem_ack seen outside RMISS/WRITE is ignored.
- Latency, with mem_ack in the k-th cycle of mem_req (k≥1):
  - Read miss or write: stall lasts 1+k cycles, then one RESP cycle.
  - Read hit: 0 stall cycles.
- Reset:
  - All valid bits cleared, state=IDLE.
  - mem_req=0, mem_we=0, mem_adr=0, mem_wd=0, resp_data=0.
  - cpu_stall follows the IDLE rules.
- Reset mid-transaction:
  - The outstanding request is abandoned; mem_req=0 from the cycle after the reset edge.
  - A late mem_ack is ignored.
  - No line is written.
- Tag/data arrays need no reset; only valid bits are reset.
- Index wrap: addresses differing only in tag map to the same line; a fill overwrites the line (conflict eviction).

Test Plan:
- Reset, then read 0x100 → stall=1 for 1+k cycles, mem_req=1 with mem_adr=0x100 and we=0. Ack with mem_rd=0xDEADBEEF → RESP cycle: cpu_rd=0xDEADBEEF, stall=0. Re-read 0x100 → hit, cpu_rd=0xDEADBEEF, stall=0, mem_req stays 0.
- Write 0x100 ← 0x12345678 after the fill above → mem_req=1, we=1, wd=0x12345678. Ack → RESP. Then read 0x100 → hit, cpu_rd=0x12345678 with no bus traffic.
- Write 0x200 ← 0xAAAA5555 to a cold line → bus write issued. Then read 0x200 → miss (no allocate) and a bus read is issued.
- Conflict: fill 0x104 (index 1), then read 0x144 (same index, different tag) → miss and refill. Then read 0x104 → miss again.
- Bus latency sweep: mem_ack delayed 1, 3 and 10 cycles → stall length 2, 4 and 11 cycles. mem_adr/mem_wd are stable throughout. A spurious mem_ack pulse while in IDLE has no effect.
- Reset asserted during RMISS with ack pending → mem_req=0 on the next cycle. A later ack is ignored. Read of the same address → miss (valid cleared).
